// File: rtl/wb_linefetch.sv
// Wishbone frame reader: fetches nlines x linewords words (line starts spaced by a stride) in
// bursts of at most 2^LGBURST words into a FIFO and streams them out tagged with sof/eol.
module wb_linefetch #(
  parameter int unsigned AW      = 24,
  parameter int unsigned DW      = 32,
  parameter int unsigned LGFIFO  = 11,
  parameter int unsigned LW      = 12,
  parameter int unsigned LGBURST = 6
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_en,
  input  logic          i_newframe,
  input  logic [AW-1:0] i_baseaddr,
  input  logic [AW-1:0] i_lineaddr,
  input  logic [LW-1:0] i_linewords,
  input  logic [LW-1:0] i_nlines,
  output logic          o_wb_cyc,
  output logic          o_wb_stb,
  output logic [AW-1:0] o_wb_addr,
  input  logic          i_wb_ack,
  input  logic          i_wb_stall,
  input  logic          i_wb_err,
  input  logic [DW-1:0] i_wb_data,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [DW-1:0] o_data,
  output logic          o_sof,
  output logic          o_eol,
  output logic          o_busy,
  output logic          o_err
);
  localparam int unsigned Depth    = 1 << LGFIFO;
  localparam int unsigned MaxBurst = 1 << LGBURST;
  localparam int unsigned CW       = LGFIFO + 1;
  localparam int unsigned BW       = LGBURST + 1;
  localparam int unsigned EW       = DW + 2;

  typedef enum logic [1:0] {StIdle, StRoom, StBurst, StDrain} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     stride_q, stride_d, line_start_q, line_start_d, addr_q, addr_d;
  logic [LW-1:0]     lw_q, lw_d, nl_q, nl_d, line_q, line_d, col_q, col_d;
  logic [BW-1:0]     blen_q, blen_d, req_q, req_d, ack_q, ack_d;
  logic              cyc_q, cyc_d, stb_q, stb_d, busy_q, busy_d, err_q, err_d;
  logic [EW-1:0]     mem_q [Depth];
  logic [LGFIFO-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]     count_q, count_d;

  logic [LW-1:0] remaining, col_next;
  logic [BW-1:0] blen_next;
  logic [CW-1:0] reserved, space;
  logic          room_ok, req_ok, ack_ok, last_req, last_ack, line_end_req, cfg_ok;
  logic          bus_err, flush, push, pop, sof_w, eol_w;
  logic [EW-1:0] head;

  always_comb begin
    remaining    = lw_q - col_q;
    blen_next    = (remaining >= LW'(MaxBurst)) ? BW'(MaxBurst) : remaining[BW-1:0];
    // requests issued but not yet acknowledged still own FIFO slots
    reserved     = CW'(req_q - ack_q);
    space        = CW'(Depth) - count_q - reserved;
    room_ok      = space >= CW'(blen_next);
    req_ok       = stb_q && !i_wb_stall;
    ack_ok       = cyc_q && i_wb_ack;
    last_req     = req_ok && (req_q == blen_q - BW'(1));
    last_ack     = ack_ok && (ack_q == blen_q - BW'(1));
    line_end_req = (col_q + LW'(req_q)) == (lw_q - LW'(1));
    col_next     = col_q + LW'(blen_q);
    cfg_ok       = (i_linewords != '0) && (i_nlines != '0);
    bus_err      = cyc_q && i_wb_err;
    flush        = i_newframe || bus_err;
    push         = ack_ok && !flush;
    pop          = (count_q != '0) && i_ready;
    sof_w        = (line_q == '0) && (col_q == '0) && (ack_q == '0);
    eol_w        = (col_q + LW'(ack_q)) == (lw_q - LW'(1));
  end

  always_comb begin
    state_d      = state_q;
    stride_d     = stride_q;
    line_start_d = line_start_q;
    addr_d       = addr_q;
    lw_d         = lw_q;
    nl_d         = nl_q;
    line_d       = line_q;
    col_d        = col_q;
    blen_d       = blen_q;
    req_d        = req_q;
    ack_d        = ack_q;
    cyc_d        = cyc_q;
    stb_d        = stb_q;
    err_d        = err_q;
    if (i_newframe) begin
      cyc_d = 1'b0;
      stb_d = 1'b0;
      err_d = 1'b0;
      req_d = '0;
      ack_d = '0;
      if (i_en && cfg_ok) begin
        stride_d     = i_lineaddr;
        line_start_d = i_baseaddr;
        addr_d       = i_baseaddr;
        lw_d         = i_linewords;
        nl_d         = i_nlines;
        line_d       = '0;
        col_d        = '0;
        state_d      = StRoom;
      end else begin
        state_d = StIdle;
      end
    end else if (bus_err) begin
      cyc_d   = 1'b0;
      stb_d   = 1'b0;
      err_d   = 1'b1;
      req_d   = '0;
      ack_d   = '0;
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: ;
        StRoom: begin
          if (room_ok) begin
            blen_d  = blen_next;
            req_d   = '0;
            ack_d   = '0;
            cyc_d   = 1'b1;
            stb_d   = 1'b1;
            state_d = StBurst;
          end
        end
        StBurst: begin
          if (req_ok) begin
            req_d = req_q + BW'(1);
            if (line_end_req) begin
              line_start_d = line_start_q + stride_q;
              addr_d       = line_start_q + stride_q;
            end else begin
              addr_d = addr_q + AW'(1);
            end
            if (last_req) begin
              stb_d   = 1'b0;
              state_d = StDrain;
            end
          end
          if (ack_ok) ack_d = ack_q + BW'(1);
        end
        StDrain: begin
          if (ack_ok) ack_d = ack_q + BW'(1);
          if (last_ack) begin
            cyc_d = 1'b0;
            req_d = '0;
            ack_d = '0;
            if (col_next == lw_q) begin
              col_d   = '0;
              line_d  = line_q + LW'(1);
              state_d = (line_q + LW'(1) == nl_q) ? StIdle : StRoom;
            end else begin
              col_d   = col_next;
              state_d = StRoom;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
    busy_d = (state_d != StIdle);
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + LGFIFO'(1);
      if (pop)  rptr_d = rptr_q + LGFIFO'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= StIdle;
      stride_q     <= '0;
      line_start_q <= '0;
      addr_q       <= '0;
      lw_q         <= '0;
      nl_q         <= '0;
      line_q       <= '0;
      col_q        <= '0;
      blen_q       <= '0;
      req_q        <= '0;
      ack_q        <= '0;
      cyc_q        <= 1'b0;
      stb_q        <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      stride_q     <= stride_d;
      line_start_q <= line_start_d;
      addr_q       <= addr_d;
      lw_q         <= lw_d;
      nl_q         <= nl_d;
      line_q       <= line_d;
      col_q        <= col_d;
      blen_q       <= blen_d;
      req_q        <= req_d;
      ack_q        <= ack_d;
      cyc_q        <= cyc_d;
      stb_q        <= stb_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
    end
  end

  // storage array needs no reset: entries are only read while count_q says they are valid
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wptr_q] <= {sof_w, eol_w, i_wb_data};
  end

  assign head      = mem_q[rptr_q];
  assign o_valid   = (count_q != '0);
  assign o_data    = o_valid ? head[DW-1:0] : '0;
  assign o_sof     = o_valid && head[DW+1];
  assign o_eol     = o_valid && head[DW];
  assign o_wb_cyc  = cyc_q;
  assign o_wb_stb  = stb_q;
  assign o_wb_addr = addr_q;
  assign o_busy    = busy_q;
  assign o_err     = err_q;

endmodule

// File: tb/tb_wb_linefetch.sv
// Directed bench for wb_linefetch: pipelined Wishbone slave model, bus/stream monitor and
// linear test sequence with immediate-assertion checks.
module tb_wb_linefetch;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, newframe;
  logic [23:0] baseaddr, lineaddr;
  logic [11:0] linewords, nlines;
  logic        cyc, stb, stall, wb_ack, wb_err;
  logic [23:0] addr;
  logic [31:0] wb_data, data;
  logic        valid, ready, sof, eol, busy, err;

  // slave model and manual override
  logic        auto, m_ack, s_ack, s_err;
  logic [31:0] m_data, s_data;
  int          err_on, s_num;
  logic [23:0] sq[$];

  // monitor state
  logic [23:0] req_log[$];
  logic [33:0] out_q[$];
  int          bursts[$];
  int          acc_reqs, acc_acks, pops, err_seen, periods, cur_burst, max_occ, stb_full, occ;
  logic        cyc_prev;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  wb_linefetch #(.AW(24), .DW(32), .LGFIFO(3), .LW(12), .LGBURST(2)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_en(en), .i_newframe(newframe),
    .i_baseaddr(baseaddr), .i_lineaddr(lineaddr), .i_linewords(linewords), .i_nlines(nlines),
    .o_wb_cyc(cyc), .o_wb_stb(stb), .o_wb_addr(addr), .i_wb_ack(wb_ack),
    .i_wb_stall(stall), .i_wb_err(wb_err), .i_wb_data(wb_data),
    .o_valid(valid), .i_ready(ready), .o_data(data), .o_sof(sof), .o_eol(eol),
    .o_busy(busy), .o_err(err)
  );

  assign wb_ack  = auto ? s_ack : m_ack;
  assign wb_data = auto ? s_data : m_data;
  assign wb_err  = auto ? s_err : 1'b0;
  assign occ     = acc_reqs - pops;

  function automatic logic [31:0] mk(input logic [23:0] a);
    return {8'hD0, a};
  endfunction

  // acks each accepted request in the following cycle; forgets everything when cyc drops
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ack <= 1'b0; s_err <= 1'b0; s_data <= '0; s_num <= 0; sq.delete();
    end else begin
      s_ack <= 1'b0;
      s_err <= 1'b0;
      if (!cyc) begin
        sq.delete();
        s_num <= 0;
      end else begin
        if (stb && !stall) sq.push_back(addr);
        if (sq.size() > 0) begin
          if (s_num + 1 == err_on) s_err <= 1'b1;
          else begin
            s_ack  <= 1'b1;
            s_data <= mk(sq[0]);
          end
          s_num <= s_num + 1;
          void'(sq.pop_front());
        end
      end
    end
  end

  always @(posedge clk) begin
    if (!rst_n || newframe) begin
      req_log.delete(); out_q.delete(); bursts.delete();
      acc_reqs <= 0; acc_acks <= 0; pops <= 0; err_seen <= 0; periods <= 0;
      cur_burst <= 0; max_occ <= 0; stb_full <= 0; cyc_prev <= cyc;
    end else begin
      if (cyc && stb && !stall) begin
        req_log.push_back(addr);
        acc_reqs  <= acc_reqs + 1;
        cur_burst <= cur_burst + 1;
      end
      if (cyc && wb_ack) acc_acks <= acc_acks + 1;
      if (cyc && wb_err) err_seen <= err_seen + 1;
      if (valid && ready) begin
        out_q.push_back({sof, eol, data});
        pops <= pops + 1;
      end
      if (cyc && !cyc_prev) periods <= periods + 1;
      if (!cyc && cyc_prev) begin
        bursts.push_back(cur_burst);
        cur_burst <= 0;
      end
      if (cyc && stb && occ >= 8) stb_full <= stb_full + 1;
      if (occ > max_occ) max_occ <= occ;
      cyc_prev <= cyc;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [23:0] b, input logic [23:0] s, input logic [11:0] lw,
                       input logic [11:0] nl);
    @(negedge clk);
    baseaddr = b; lineaddr = s; linewords = lw; nlines = nl; en = 1'b1; newframe = 1'b1;
    @(negedge clk);
    newframe = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int n);
    int k = 0;
    while ((out_q.size() < n || busy) && k < 500) begin
      @(negedge clk);
      k++;
    end
    repeat (2) @(negedge clk);
    chk(tag, out_q.size(), n);
  endtask

  task automatic wait_reqs(input string tag, input int n);
    int k = 0;
    while (acc_reqs < n && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk(tag, acc_reqs, n);
  endtask

  task automatic wait_acks(input string tag, input int n);
    int k = 0;
    while (acc_acks < n && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk(tag, acc_acks, n);
  endtask

  initial begin
    logic [33:0] w;
    int          eols;
    rst_n = 1'b0; en = 1'b0; newframe = 1'b0; stall = 1'b0; ready = 1'b1;
    baseaddr = '0; lineaddr = '0; linewords = '0; nlines = '0;
    auto = 1'b1; m_ack = 1'b0; m_data = '0; err_on = 0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {cyc, stb, addr, valid, data, sof, eol, busy, err}, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: two lines of four words
    start(24'h100, 24'h10, 12'd4, 12'd2);
    chk("t1_busy", busy, 1'b1);
    wait_acks("t1_first_ack", 1);
    chk("t1_first_valid", {valid, sof, eol, data}, {3'b110, 32'hD000_0100});
    wait_done("t1_words", 8);
    chk("t1_busy_low", busy, 1'b0);
    chk("t1_acks", acc_acks, 8);
    chk("t1_periods", periods, 2);
    for (int i = 0; i < 8; i++) begin
      chk("t1_addr", req_log[i], (i < 4) ? 24'h100 + 24'(i) : 24'h10C + 24'(i));
      w = {(i == 0), (i % 4 == 3), mk((i < 4) ? 24'h100 + 24'(i) : 24'h10C + 24'(i))};
      chk("t1_word", out_q[i], w);
    end

    // 2: ten-word line split into 4,4,2 bursts
    start(24'h200, 24'h40, 12'd10, 12'd1);
    wait_done("t2_words", 10);
    chk("t2_periods", periods, 3);
    chk("t2_burst0", bursts[0], 4);
    chk("t2_burst1", bursts[1], 4);
    chk("t2_burst2", bursts[2], 2);
    eols = 0;
    for (int i = 0; i < 10; i++) begin
      chk("t2_addr", req_log[i], 24'h200 + 24'(i));
      if (out_q[i][32]) eols++;
    end
    chk("t2_eol_count", eols, 1);
    chk("t2_eol_last", out_q[9][32], 1'b1);

    // 3: twenty-word line against an 8-deep FIFO with the consumer stalled
    ready = 1'b0;
    start(24'h400, 24'h100, 12'd20, 12'd1);
    repeat (60) @(negedge clk);
    chk("t3_reqs_capped", acc_reqs, 8);
    chk("t3_no_stb_full", stb, 1'b0);
    chk("t3_stb_full_cnt", stb_full, 0);
    chk("t3_valid_held", {valid, data}, {1'b1, 32'hD000_0400});
    ready = 1'b1;
    wait_done("t3_words", 20);
    chk("t3_max_occ", max_occ, 8);
    chk("t3_stb_full_end", stb_full, 0);
    for (int i = 0; i < 20; i++) begin
      w = {(i == 0), (i == 19), mk(24'h400 + 24'(i))};
      chk("t3_word", out_q[i], w);
    end

    // 4: stall held for three cycles mid-burst
    start(24'h300, 24'h10, 12'd4, 12'd1);
    wait_reqs("t4_two_reqs", 2);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t4_stall_hold", {stb, addr, 8'(acc_reqs)}, {1'b1, 24'h302, 8'd2});
    end
    stall = 1'b0;
    wait_done("t4_words", 4);
    chk("t4_reqs", req_log.size(), 4);
    chk("t4_addr2", req_log[2], 24'h302);
    chk("t4_addr3", req_log[3], 24'h303);

    // 5: bus error on the second ack
    ready = 1'b0;
    err_on = 2;
    start(24'h700, 24'h10, 12'd4, 12'd2);
    begin
      int k = 0;
      while (err_seen < 1 && k < 100) begin
        @(negedge clk);
        k++;
      end
    end
    chk("t5_err_seen", err_seen, 1);
    chk("t5_after_err", {cyc, stb, err, valid, busy}, 5'b00100);
    repeat (3) @(negedge clk);
    chk("t5_err_sticky", {err, busy}, 2'b10);
    err_on = 0;
    ready = 1'b1;
    start(24'h700, 24'h10, 12'd4, 12'd1);
    chk("t5_err_cleared", err, 1'b0);
    wait_done("t5_words", 4);
    chk("t5_first_word", out_q[0], {2'b10, 32'hD000_0700});

    // 6: newframe with two acks outstanding; late acks must be dropped
    auto = 1'b0;
    start(24'h800, 24'h10, 12'd4, 12'd1);
    wait_reqs("t6_two_reqs", 2);
    baseaddr = 24'h500; newframe = 1'b1; m_ack = 1'b1; m_data = 32'hBAD0_BAD0;
    @(negedge clk);
    newframe = 1'b0;
    chk("t6_abort", {cyc, stb, busy, valid}, 4'b0010);
    @(negedge clk);
    m_ack = 1'b0;
    auto = 1'b1;
    wait_done("t6_words", 4);
    chk("t6_first_word", out_q[0], {2'b10, 32'hD000_0500});
    chk("t6_first_addr", req_log[0], 24'h500);
    chk("t6_acks", acc_acks, 4);

    // asynchronous reset in the middle of a burst
    ready = 1'b0;
    start(24'h600, 24'h10, 12'd8, 12'd1);
    wait_acks("t7_first_ack", 1);
    chk("t7_pre_reset", {cyc, stb, valid}, 3'b111);
    #2 rst_n = 1'b0;
    #1 chk("t7_reset_outputs", {cyc, stb, addr, valid, data, sof, eol, busy, err}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

endmodule
